sfr_uart: RTL and testbench

- SFR-bus responder for the r8051 core. Implements the classic 8051 serial port: SCON at 0x98 and SBUF at 0x99, 8-N-1 framing.
- Decodes the core's ram_*_sfr read/write strobes and returns read data with 1-cycle latency, matching the data/xdata RAM read path.
- Sits beside the data RAM in R8051; its sfr_rd_byte feeds the read_flag[1] leg of the ram_rd_byte mux.

---
 rtl/r8051_sfr_pkg.sv | 26 ++
 rtl/sfr_uart_if.sv | 21 ++
 rtl/sfr_uart_rx.sv | 81 ++++++++
 rtl/sfr_uart.sv | 125 ++++++++++++
 tb/tb_sfr_uart.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/r8051_sfr_pkg.sv
// Shared definitions for r8051 SFR-bus peripherals: SFR addresses, SCON bit
// positions and the serial-port FSM state encodings.
package r8051_sfr_pkg;

  localparam logic [7:0] SFR_SCON = 8'h98;
  localparam logic [7:0] SFR_SBUF = 8'h99;

  localparam int SCON_RI  = 0;
  localparam int SCON_TI  = 1;
  localparam int SCON_REN = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/sfr_uart_if.sv
// r8051 SFR bus as seen by one responder: read/write strobes, addresses,
// write data, and the registered read data with its address-hit flag.
interface sfr_uart_if;
  logic       ram_rd_en_sfr;
  logic [7:0] ram_rd_addr;
  logic [7:0] sfr_rd_byte;
  logic       sfr_rd_hit;
  logic       ram_wr_en_sfr;
  logic [7:0] ram_wr_addr;
  logic [7:0] ram_wr_byte;

  modport master (
    output ram_rd_en_sfr, ram_rd_addr, ram_wr_en_sfr, ram_wr_addr, ram_wr_byte,
    input  sfr_rd_byte, sfr_rd_hit
  );

  modport slave (
    input  ram_rd_en_sfr, ram_rd_addr, ram_wr_en_sfr, ram_wr_addr, ram_wr_byte,
    output sfr_rd_byte, sfr_rd_hit
  );
endinterface

// File: rtl/sfr_uart_rx.sv
// 8-N-1 receiver: 2-flop rxd synchronizer, mid-bit sampling FSM and shifter.
// rx_done pulses once per completed frame; frame_err qualifies it (stop bit 0).
module sfr_uart_rx
  import r8051_sfr_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       ren,
  output logic       rx_done,
  output logic [7:0] rx_data,
  output logic       frame_err
);
  localparam int            TW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLK_DIV / 2 - 1);

  rx_state_e     state, next;
  logic          sync1, sync2, rxd_prev;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          tick;

  assign tick    = (timer == '0);
  assign rx_data = shift;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      sync1    <= rxd;
      sync2    <= sync1;
      rxd_prev <= sync2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RX_IDLE;
    else      state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      RX_IDLE:  if (ren && rxd_prev && !sync2) next = RX_START;
      RX_START: if (tick) next = sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_cnt == 3'd7) next = RX_STOP;
      RX_STOP:  if (tick) next = RX_IDLE;
      default:  next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_done   = (state == RX_STOP) && tick;
    frame_err = rx_done && !sync2;
  end

  // Idle keeps the timer at the half-bit reload so START lands mid-bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer   <= HALF_LAST;
      bit_cnt <= 3'd0;
    end else begin
      if (state == RX_IDLE) timer <= HALF_LAST;
      else if (tick)        timer <= BIT_LAST;
      else                  timer <= timer - TW'(1);
      if (state != RX_DATA) bit_cnt <= 3'd0;
      else if (tick)        bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == RX_DATA && tick) shift <= {sync2, shift[7:1]};
  end

endmodule

// File: rtl/sfr_uart.sv
// 8051 serial port (SCON/SBUF) on the r8051 SFR bus, 8-N-1 framing.
// Holds the SFR decode, SCON, the rx buffer and the transmitter.
module sfr_uart
  import r8051_sfr_pkg::*;
#(
  parameter int         CLK_DIV   = 16,
  parameter logic [7:0] SCON_ADDR = SFR_SCON,
  parameter logic [7:0] SBUF_ADDR = SFR_SBUF
) (
  input  logic      clk,
  input  logic      rst,
  sfr_uart_if.slave bus,
  input  logic      rxd,
  output logic      txd,
  output logic      tx_busy
);
  localparam int            TW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] BIT_LAST = TW'(CLK_DIV - 1);

  tx_state_e     tx_state, tx_next;
  logic [TW-1:0] tx_timer;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_tick, tx_done;
  logic [7:0]    scon, rx_buf, rx_data;
  logic          rx_done, frame_err, rx_load;
  logic          wr_scon, wr_sbuf;

  assign wr_scon = bus.ram_wr_en_sfr && (bus.ram_wr_addr == SCON_ADDR);
  assign wr_sbuf = bus.ram_wr_en_sfr && (bus.ram_wr_addr == SBUF_ADDR);
  assign tx_tick = (tx_timer == '0);
  // A good frame arriving while RI is still set is an overrun and is dropped.
  assign rx_load = rx_done && !frame_err && !scon[SCON_RI];

  sfr_uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .ren      (scon[SCON_REN]),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .frame_err(frame_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx_state <= TX_IDLE;
    else      tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (wr_sbuf) tx_next = TX_START;
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // txd decodes straight from state so an async reset forces the line high.
  always_comb begin
    txd     = 1'b1;
    tx_busy = 1'b1;
    tx_done = 1'b0;
    case (tx_state)
      TX_IDLE:  tx_busy = 1'b0;
      TX_START: txd     = 1'b0;
      TX_DATA:  txd     = tx_shift[0];
      TX_STOP:  tx_done = tx_tick;
      default:  tx_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_timer <= BIT_LAST;
      tx_bit   <= 3'd0;
    end else begin
      if (tx_state == TX_IDLE || tx_tick) tx_timer <= BIT_LAST;
      else                                tx_timer <= tx_timer - TW'(1);
      if (tx_state != TX_DATA) tx_bit <= 3'd0;
      else if (tx_tick)        tx_bit <= tx_bit + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_state == TX_IDLE && wr_sbuf)     tx_shift <= bus.ram_wr_byte;
    else if (tx_state == TX_DATA && tx_tick) tx_shift <= {1'b0, tx_shift[7:1]};
  end

  // Hardware sets of TI/RI are written last so they override a same-cycle write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scon   <= 8'h00;
      rx_buf <= 8'h00;
    end else begin
      if (wr_scon) scon <= bus.ram_wr_byte;
      if (tx_done) scon[SCON_TI] <= 1'b1;
      if (rx_load) begin
        scon[SCON_RI] <= 1'b1;
        rx_buf        <= rx_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.sfr_rd_byte <= 8'h00;
      bus.sfr_rd_hit  <= 1'b0;
    end else if (bus.ram_rd_en_sfr) begin
      if (bus.ram_rd_addr == SCON_ADDR) begin
        bus.sfr_rd_byte <= scon;
        bus.sfr_rd_hit  <= 1'b1;
      end else if (bus.ram_rd_addr == SBUF_ADDR) begin
        bus.sfr_rd_byte <= rx_buf;
        bus.sfr_rd_hit  <= 1'b1;
      end else begin
        bus.sfr_rd_byte <= 8'h00;
        bus.sfr_rd_hit  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sfr_uart.sv
// Bench for sfr_uart: read/write vector table, directed serial frames and a
// randomized mix checked against a transaction-level model of SCON/SBUF.
module tb_sfr_uart;
  import r8051_sfr_pkg::*;

  localparam int CLK_DIV = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rxd = 1'b1;
  logic txd, tx_busy;

  sfr_uart_if bus();

  sfr_uart #(.CLK_DIV(CLK_DIV), .SCON_ADDR(8'h98), .SBUF_ADDR(8'h99)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .rxd    (rxd),
    .txd    (txd),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] m_scon = 8'h00;
  logic [7:0] m_buf  = 8'h00;

  typedef struct {
    string      name;
    logic       wr;
    logic [7:0] wa;
    logic [7:0] wd;
    logic       rd;
    logic [7:0] ra;
    logic [7:0] eb;
    logic       eh;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
    end
  endtask

  task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.ram_wr_en_sfr = 1'b1;
    bus.ram_wr_addr   = a;
    bus.ram_wr_byte   = d;
    @(negedge clk);
    bus.ram_wr_en_sfr = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [7:0] a);
    logic [7:0] eb;
    logic       eh;
    eh = (a == 8'h98) || (a == 8'h99);
    eb = (a == 8'h98) ? m_scon : (a == 8'h99) ? m_buf : 8'h00;
    @(negedge clk);
    bus.ram_rd_en_sfr = 1'b1;
    bus.ram_rd_addr   = a;
    @(negedge clk);
    bus.ram_rd_en_sfr = 1'b0;
    chk({name, "_byte"}, bus.sfr_rd_byte, eb);
    chk({name, "_hit"}, {7'd0, bus.sfr_rd_hit}, {7'd0, eh});
  endtask

  // Sends d, checks every bit mid-cell, busy/TI timing; optionally writes SBUF mid-frame.
  task automatic tx_frame(input logic [7:0] d, input logic inject);
    logic expb;
    logic idle_ok;
    @(negedge clk);
    bus.ram_wr_en_sfr = 1'b1;
    bus.ram_wr_addr   = 8'h99;
    bus.ram_wr_byte   = d;
    @(negedge clk);
    bus.ram_wr_en_sfr = 1'b0;
    chk("tx_busy_start", {7'd0, tx_busy}, 8'd1);
    repeat (CLK_DIV / 2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      expb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : d[k-1];
      chk($sformatf("txd_bit%0d", k), {7'd0, txd}, {7'd0, expb});
      if (inject && k == 3) begin
        bus.ram_wr_en_sfr = 1'b1;
        bus.ram_wr_addr   = 8'h99;
        bus.ram_wr_byte   = 8'h3C;
        @(negedge clk);
        bus.ram_wr_en_sfr = 1'b0;
        repeat (CLK_DIV - 1) @(negedge clk);
      end else if (k < 9) begin
        repeat (CLK_DIV) @(negedge clk);
      end
    end
    repeat (CLK_DIV / 2 - 1) @(negedge clk);
    chk("tx_busy_last", {7'd0, tx_busy}, 8'd1);
    bus.ram_rd_en_sfr = 1'b1;
    bus.ram_rd_addr   = 8'h98;
    @(negedge clk);
    chk("tx_busy_end", {7'd0, tx_busy}, 8'd0);
    chk("scon_before_ti", bus.sfr_rd_byte, m_scon);
    m_scon[SCON_TI] = 1'b1;
    @(negedge clk);
    bus.ram_rd_en_sfr = 1'b0;
    chk("scon_after_ti", bus.sfr_rd_byte, m_scon);
    if (inject) begin
      idle_ok = 1'b1;
      repeat (2 * CLK_DIV) begin
        @(negedge clk);
        if (!txd || tx_busy) idle_ok = 1'b0;
      end
      chk("tx_no_second_frame", {7'd0, idle_ok}, 8'd1);
    end
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    rxd = stop;
    repeat (CLK_DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    if (m_scon[SCON_REN] && stop && !m_scon[SCON_RI]) begin
      m_buf           = d;
      m_scon[SCON_RI] = 1'b1;
    end
  endtask

  vec_t vecs[10];

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic [7:0] a;
    bus.ram_rd_en_sfr = 1'b0;
    bus.ram_rd_addr   = 8'h00;
    bus.ram_wr_en_sfr = 1'b0;
    bus.ram_wr_addr   = 8'h00;
    bus.ram_wr_byte   = 8'h00;

    vecs[0] = '{"rst_scon",  1'b0, 8'h00, 8'h00, 1'b1, 8'h98, 8'h00, 1'b1};
    vecs[1] = '{"rd_other",  1'b0, 8'h00, 8'h00, 1'b1, 8'h80, 8'h00, 1'b0};
    vecs[2] = '{"rst_sbuf",  1'b0, 8'h00, 8'h00, 1'b1, 8'h99, 8'h00, 1'b1};
    vecs[3] = '{"wr_scon",   1'b1, 8'h98, 8'hC3, 1'b1, 8'h98, 8'hC3, 1'b1};
    vecs[4] = '{"hold_hit",  1'b0, 8'h00, 8'h00, 1'b0, 8'h80, 8'hC3, 1'b1};
    vecs[5] = '{"wr_undec",  1'b1, 8'h97, 8'hFF, 1'b1, 8'h98, 8'hC3, 1'b1};
    vecs[6] = '{"rd_81",     1'b0, 8'h00, 8'h00, 1'b1, 8'h81, 8'h00, 1'b0};
    vecs[7] = '{"hold_miss", 1'b0, 8'h00, 8'h00, 1'b0, 8'h98, 8'h00, 1'b0};
    vecs[8] = '{"wr_ren",    1'b1, 8'h98, 8'h10, 1'b1, 8'h98, 8'h10, 1'b1};
    vecs[9] = '{"rd_sbuf",   1'b0, 8'h00, 8'h00, 1'b1, 8'h99, 8'h00, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_txd", {7'd0, txd}, 8'd1);
    chk("rst_busy", {7'd0, tx_busy}, 8'd0);
    chk("rst_rd_byte", bus.sfr_rd_byte, 8'h00);
    chk("rst_rd_hit", {7'd0, bus.sfr_rd_hit}, 8'd0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) sfr_write(vecs[i].wa, vecs[i].wd);
      @(negedge clk);
      bus.ram_rd_en_sfr = vecs[i].rd;
      bus.ram_rd_addr   = vecs[i].ra;
      @(negedge clk);
      bus.ram_rd_en_sfr = 1'b0;
      chk({vecs[i].name, "_byte"}, bus.sfr_rd_byte, vecs[i].eb);
      chk({vecs[i].name, "_hit"}, {7'd0, bus.sfr_rd_hit}, {7'd0, vecs[i].eh});
    end

    // Transmit: clean frame from SCON=0, then a frame with a dropped SBUF write.
    sfr_write(8'h98, 8'h00);
    m_scon = 8'h00;
    tx_frame(8'hA5, 1'b0);
    chk("scon_after_tx", m_scon, 8'h02);
    read_check("scon_tx", 8'h98);
    tx_frame(8'hA5, 1'b1);

    // Receive: good frame, overrun, false start, framing error.
    sfr_write(8'h98, 8'h10);
    m_scon = 8'h10;
    rx_frame(8'h5A, 1'b1);
    read_check("rx_scon", 8'h98);
    read_check("rx_sbuf", 8'h99);
    rx_frame(8'h11, 1'b1);
    read_check("ovr_sbuf", 8'h99);
    read_check("ovr_sbuf_again", 8'h99);
    sfr_write(8'h98, 8'h10);
    m_scon = 8'h10;
    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk);
    read_check("false_start_scon", 8'h98);
    rx_frame(8'h77, 1'b0);
    read_check("ferr_scon", 8'h98);
    read_check("ferr_sbuf", 8'h99);

    // Randomized mix against the model.
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0: begin
          r = 8'($urandom);
          sfr_write(8'h98, r);
          m_scon = r;
          read_check("rnd_wr_scon", 8'h98);
        end
        1: tx_frame(8'($urandom), 1'b0);
        2: begin
          rx_frame(8'($urandom), $urandom_range(0, 3) != 0);
          read_check("rnd_rx_sbuf", 8'h99);
          read_check("rnd_rx_scon", 8'h98);
        end
        default: begin
          a = ($urandom_range(0, 1) != 0) ? 8'(8'h98 + $urandom_range(0, 1)) : 8'($urandom);
          read_check("rnd_rd", a);
        end
      endcase
    end

    // Reset in the middle of data bit 3 of 0xA5 (bit value 0).
    @(negedge clk);
    bus.ram_wr_en_sfr = 1'b1;
    bus.ram_wr_addr   = 8'h99;
    bus.ram_wr_byte   = 8'hA5;
    @(negedge clk);
    bus.ram_wr_en_sfr = 1'b0;
    repeat (4 * CLK_DIV + CLK_DIV / 2) @(negedge clk);
    chk("mid_tx_txd", {7'd0, txd}, 8'd0);
    #2 rst = 1'b0;
    #1;
    chk("arst_txd", {7'd0, txd}, 8'd1);
    chk("arst_busy", {7'd0, tx_busy}, 8'd0);
    @(negedge clk);
    rst    = 1'b1;
    m_scon = 8'h00;
    m_buf  = 8'h00;
    read_check("post_rst_scon", 8'h98);
    read_check("post_rst_sbuf", 8'h99);
    tx_frame(8'h01, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
